// File: rtl/bin2thermo_dwa_pkg.sv
// Shared constants, FSM state type and code clamp for the unit-cell DAC encoder.
// Element count is fixed here; the code width is derived from it.
package bin2thermo_dwa_pkg;

    localparam int N_ELEM = 8;
    localparam int CODE_W = $clog2(N_ELEM + 1);
    localparam int PTR_W  = $clog2(N_ELEM);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // Out-of-range codes saturate to full scale (all elements on).
    function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
        return (code > CODE_W'(N_ELEM)) ? CODE_W'(N_ELEM) : code;
    endfunction

endpackage

// File: rtl/bin2thermo_dwa_mask.sv
// Element-select mask: n-bit thermometer, optionally rotated left by the DWA pointer.
// Purely combinational; no state, no handshake.
module therm_mask_gen
    import bin2thermo_dwa_pkg::*;
(
    input  logic [CODE_W-1:0] n,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              dwa_en,
    output logic [N_ELEM-1:0] mask,
    output logic [PTR_W-1:0]  ptr_next
);

    logic [N_ELEM-1:0]   base;
    logic [2*N_ELEM-1:0] dbl;

    always_comb begin
        for (int i = 0; i < N_ELEM; i++) begin
            base[i] = (CODE_W'(i) < n);
        end
        // Upper half of the doubled word shifted left is the circular rotation.
        dbl = {base, base} << ptr;
        if (dwa_en) begin
            mask     = dbl[2*N_ELEM-1:N_ELEM];
            // N_ELEM is a power of two, so truncation is the modulo; n==N_ELEM leaves ptr unchanged.
            ptr_next = ptr + n[PTR_W-1:0];
        end else begin
            mask     = base;
            ptr_next = '0;
        end
    end

endmodule

// File: rtl/bin2thermo_dwa.sv
// Binary-to-thermometer DAC driver: one sample per OSF clocks, optional DWA rotation.
// Latency 1 clock accept-to-Therm; Ready only in IDLE or last hold cycle, samples offered otherwise are dropped.
module bin2thermo_dwa
    import bin2thermo_dwa_pkg::*;
#(
    parameter int OSF = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CODE_W-1:0] Code,
    input  logic              Valid,
    output logic              Ready,
    input  logic              DwaEn,
    output logic [N_ELEM-1:0] Therm,
    output logic              Sat,
    output logic              Underrun
);

    localparam int               CNT_W    = (OSF > 1) ? $clog2(OSF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OSF - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [N_ELEM-1:0] mask;
    logic [CODE_W-1:0] n;
    logic              accept;
    logic              period_end;

    assign n          = clamp_code(Code);
    assign period_end = (state == HOLD) && (cnt == '0);
    assign Ready      = (state == IDLE) || (cnt == '0);
    assign accept     = Valid && Ready;

    therm_mask_gen u_mask (
        .n        (n),
        .ptr      (ptr),
        .dwa_en   (DwaEn),
        .mask     (mask),
        .ptr_next (ptr_nxt)
    );

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = HOLD;
        end else if (period_end) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            Therm    <= '0;
            Sat      <= 1'b0;
            Underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            Sat      <= accept && (Code > CODE_W'(N_ELEM));
            Underrun <= period_end && !accept;
            if (accept) begin
                Therm <= mask;
                ptr   <= ptr_nxt;
                cnt   <= CNT_LOAD;
            end else if (period_end) begin
                // Pointer survives the underrun so the DWA sequence resumes where it stopped.
                Therm <= '0;
            end else if (state == HOLD) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin2thermo_dwa.sv
// Randomised scoreboard bench: driver pushes model results, monitor pops on each new output period.
module tb_bin2thermo_dwa;
    import bin2thermo_dwa_pkg::*;

    localparam int OSF = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [CODE_W-1:0] Code;
    logic              Valid;
    logic              Ready;
    logic              DwaEn;
    logic [N_ELEM-1:0] Therm;
    logic              Sat;
    logic              Underrun;

    bin2thermo_dwa #(.OSF(OSF)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Code     (Code),
        .Valid    (Valid),
        .Ready    (Ready),
        .DwaEn    (DwaEn),
        .Therm    (Therm),
        .Sat      (Sat),
        .Underrun (Underrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N_ELEM-1:0] therm;
        logic              sat;
        int                n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mptr   = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Reference: light elements ptr, ptr+1, ... (mod N) for DWA, else 0..n-1.
    function automatic exp_t model(input int code, input bit dwa);
        exp_t e;
        int   nn;
        nn      = (code > N_ELEM) ? N_ELEM : code;
        e.therm = '0;
        for (int k = 0; k < nn; k++) begin
            e.therm[dwa ? (mptr + k) % N_ELEM : k] = 1'b1;
        end
        mptr  = dwa ? (mptr + nn) % N_ELEM : 0;
        e.sat = (code > N_ELEM);
        e.n   = nn;
        return e;
    endfunction

    task automatic send(input int code, input bit dwa);
        bit ok;
        ok    = 1'b0;
        Code  = CODE_W'(code);
        DwaEn = dwa;
        Valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (Ready) begin
                q.push_back(model(code, dwa));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 0, 1);
        @(posedge CLK);
        #1;
        Valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    int                pos      = 0;
    bit                prev_acc = 1'b0;
    logic [N_ELEM-1:0] cur      = '0;
    exp_t              e;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                pos      = 0;
                prev_acc = 1'b0;
            end else begin
                if (prev_acc) begin
                    if (q.size() == 0) begin
                        chk("queue_empty_on_load", 0, 1);
                    end else begin
                        e = q.pop_front();
                        chk("therm_load", int'(Therm), int'(e.therm));
                        chk("sat_load", int'(Sat), int'(e.sat));
                        chk("popcount", $countones(Therm), e.n);
                        chk("underrun_on_load", int'(Underrun), 0);
                        cur = e.therm;
                    end
                    pos = 1;
                end else if (pos == OSF) begin
                    chk("therm_after_underrun", int'(Therm), 0);
                    chk("underrun_pulse", int'(Underrun), 1);
                    chk("sat_idle", int'(Sat), 0);
                    pos = 0;
                end else if (pos > 0) begin
                    pos++;
                    chk("therm_hold", int'(Therm), int'(cur));
                    chk("sat_hold", int'(Sat), 0);
                    chk("underrun_hold", int'(Underrun), 0);
                end else begin
                    chk("therm_idle", int'(Therm), 0);
                    chk("underrun_idle", int'(Underrun), 0);
                    chk("sat_idle", int'(Sat), 0);
                end
                chk("ready", int'(Ready), int'(pos == 0 || pos == OSF));
                prev_acc = Valid && Ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        RST   = 1'b1;
        Valid = 1'b0;
        Code  = '0;
        DwaEn = 1'b0;
        #12;
        chk("rst_therm", int'(Therm), 0);
        chk("rst_ready", int'(Ready), 1);
        chk("rst_sat", int'(Sat), 0);
        chk("rst_underrun", int'(Underrun), 0);
        @(negedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;

        send(3, 1'b0);
        idle(12);

        send(3, 1'b1);
        send(3, 1'b1);
        send(3, 1'b1);
        idle(12);

        send(12, 1'b1);
        send(2, 1'b1);
        idle(12);

        send(5, 1'b0);
        DwaEn = 1'b1;
        idle(12);

        send(3, 1'b1);
        send(2, 1'b1);
        repeat (3) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("async_rst_therm", int'(Therm), 0);
        chk("async_rst_ready", int'(Ready), 1);
        chk("async_rst_sat", int'(Sat), 0);
        mptr = 0;
        q.delete();
        @(negedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;
        send(2, 1'b1);
        idle(12);

        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, N_ELEM), 1'b0);
        end
        idle(12);

        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            DwaEn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
        end
        idle(20);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
